pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised program-counter unit for the multicycle datapath: holds the PC, drives the
//  instruction address (IAD) and runs a req/ack fetch handshake with instruction memory.
//  Adds advance enable (load-wait), branch/jump redirect, external trap, misaligned-target
//  trap and fetch-timeout trap, with squashing of fetches made stale by a redirect.
//  Sits between ctrl_datapath (pc_en, redirect, trap) and the instruction memory port.
// PARAMETERS
//  XLEN      32             PC / address width
//  RESET_PC  32'h0001_0000  PC loaded by reset
//  TRAP_VEC  32'h0000_0080  PC loaded on any trap
//  MAX_WAIT  15             cycles in S_FETCH without ack before timeout (1..255)
// PORTS
//  clk            in   1     clock, all state updates on rising edge
//  rst            in   1     synchronous reset, active-low
//  pc_en          in   1     advance PC to pc+4 (load-wait complete)
//  redirect_valid in   1     branch/jump taken
//  redirect_pc    in   XLEN  redirect target
//  trap           in   1     external trap request
//  imem_ack       in   1     memory accepted request; instruction valid this cycle
//  iad            out  XLEN  instruction address = current PC
//  imem_req       out  1     fetch request, held stable with iad until ack
//  if_valid       out  1     1-cycle pulse: fetched instruction accepted
//  if_pc          out  XLEN  PC of the instruction flagged by if_valid
//  epc            out  XLEN  PC (or bad target) saved on trap
//  cause          out  2     0 none, 1 fetch timeout, 2 misaligned target, 3 external trap
//  fetch_err      out  1     1-cycle pulse on timeout
// BEHAVIOUR
//  Reset (rst==0 at edge): pc=RESET_PC, state=S_FETCH, if_valid=0, if_pc=0, epc=0, cause=0,
//   fetch_err=0, pending/squash clear, wait_cnt=0. Reset mid-fetch abandons the fetch;
//   imem_req=1 with iad=RESET_PC from the first cycle after reset deasserts.
//  iad = pc always; imem_req = (state==S_FETCH), combinational from state.
//  Next-PC priority: trap > redirect_valid > pc_en (pc+4, mod 2^XLEN: FFFF_FFFC -> 0).
//  Redirect with redirect_pc[1:0]!=0: treated as trap, cause=2, epc=redirect_pc.
//  External trap: cause=3, epc=pc. Any trap loads pc=TRAP_VEC.
//  S_FETCH (request outstanding, iad/pc frozen):
//   - no ack: wait_cnt++; when wait_cnt==MAX_WAIT: fetch_err=1 (1 cycle), cause=1,
//     epc=pc, pc=TRAP_VEC, wait_cnt=0, pending/squash cleared, stay S_FETCH.
//   - trap/redirect without ack: latch target (TRAP_VEC or redirect_pc) and cause/epc into
//     pending, set squash; later trap overwrites pending redirect, never vice versa.
//   - ack with squash clear and no same-cycle trap/redirect: next cycle if_valid=1,
//     if_pc=pc; state->S_ISSUED; wait_cnt=0.
//   - ack with squash set: no if_valid; pc=pending target, squash cleared, stay S_FETCH.
//   - ack with same-cycle trap/redirect: instruction squashed, pc=new target, stay S_FETCH.
//  S_ISSUED (instruction in execution, imem_req=0):
//   - trap, redirect_valid or pc_en: pc=next-PC per priority, state->S_FETCH.
//   - otherwise hold pc. imem_ack ignored.
//  if_valid high exactly one cycle per accepted fetch; fetch_err exactly one per timeout.
//  cause/epc hold until next trap; written in the same edge that loads TRAP_VEC.
//  Latency: redirect in S_ISSUED -> iad=target next cycle; pc_en -> iad=pc+4 next cycle.
// TESTING
//  1 rst=0 two cycles then 1 -> iad=32'h0001_0000, imem_req=1, if_valid=0, cause=0.
//  2 ack 2 cycles after reset, pc_en 1 cycle later -> one if_valid pulse with
//    if_pc=0x10000; iad=0x10004, imem_req=1 after pc_en.
//  3 redirect_pc=0x2000 in S_FETCH, ack 3 cycles later -> no if_valid; iad=0x2000,
//    imem_req=1 the cycle after ack.
//  4 no ack for MAX_WAIT(15) cycles at pc=0x10000 -> fetch_err pulse, cause=1,
//    epc=0x10000, iad=0x80.
//  5 in S_ISSUED, redirect_pc=0x2002 and trap same cycle -> trap wins: cause=3,
//    epc=pc, iad=0x80; separately redirect 0x2002 alone -> cause=2, epc=0x2002, iad=0x80.
//  6 pc forced to 0xFFFF_FFFC, ack then pc_en -> iad=0x0000_0000; rst=0 mid-fetch
//    -> iad=0x10000, if_valid=0, no stale if_valid after ack.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter unit for the multicycle datapath. Holds the PC, presents it
//   as the instruction address and runs a req/ack fetch handshake with the
//   instruction memory. It handles PC advance, branch/jump redirect, external
//   traps, misaligned-target traps and fetch timeouts. It also squashes any
//   fetch that a redirect or trap has made stale.
//
// Ports
//   clk_i             clock, rising edge
//   rst_i             synchronous reset, active-low
//   pc_en_i           advance PC to pc+4 (load-wait complete)
//   redirect_valid_i  branch/jump taken
//   redirect_pc_i     redirect target
//   trap_i            external trap request
//   imem_ack_i        memory accepted the request; instruction valid this cycle
//   iad_o             instruction address (= PC)
//   imem_req_o        fetch request, held with iad_o until ack
//   if_valid_o        one-cycle pulse: fetched instruction accepted
//   if_pc_o           PC of the instruction flagged by if_valid_o
//   epc_o             PC (or bad target) saved on trap
//   cause_o           0 none, 1 fetch timeout, 2 misaligned target, 3 external trap
//   fetch_err_o       one-cycle pulse on fetch timeout
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_FETCH  | request outstanding, PC frozen, waiting for imem_ack_i
// S_ISSUED | instruction in execution, waiting for pc_en/redirect/trap
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0001_0000),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0080),
    parameter int unsigned     MAX_WAIT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_en_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic            imem_ack_i,
    output logic [XLEN-1:0] iad_o,
    output logic            imem_req_o,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] epc_o,
    output logic [1:0]      cause_o,
    output logic            fetch_err_o
);

    typedef enum logic {S_FETCH, S_ISSUED} state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
    localparam logic [1:0] CAUSE_EXT      = 2'd3;
    localparam logic [7:0] WAIT_LAST      = 8'(MAX_WAIT - 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [1:0]      cause_q, cause_d;
    logic            fetch_err_q, fetch_err_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_trap_q, pend_trap_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [1:0]      pend_cause_q, pend_cause_d;
    logic [XLEN-1:0] pend_epc_q, pend_epc_d;

    // This cycle's redirect/trap event. A misaligned redirect becomes a trap.
    logic            ev_any, ev_trap;
    logic [XLEN-1:0] ev_target, ev_epc;
    logic [1:0]      ev_cause;

    assign ev_any    = trap_i | redirect_valid_i;
    assign ev_trap   = trap_i | (redirect_valid_i & (redirect_pc_i[1:0] != 2'b00));
    assign ev_target = ev_trap ? TRAP_VEC : redirect_pc_i;
    assign ev_cause  = trap_i ? CAUSE_EXT : CAUSE_MISALIGN;
    assign ev_epc    = trap_i ? pc_q : redirect_pc_i;

    // Merge the event into the pending record. A new event replaces a pending
    // redirect, but a pending trap is only replaced by another trap.
    logic            take_new;
    logic            mrg_valid, mrg_trap;
    logic [XLEN-1:0] mrg_pc, mrg_epc;
    logic [1:0]      mrg_cause;

    assign take_new  = ev_any & (~pend_valid_q | ev_trap | ~pend_trap_q);
    assign mrg_valid = pend_valid_q | ev_any;
    assign mrg_trap  = take_new ? ev_trap   : pend_trap_q;
    assign mrg_pc    = take_new ? ev_target : pend_pc_q;
    assign mrg_cause = take_new ? ev_cause  : pend_cause_q;
    assign mrg_epc   = take_new ? ev_epc    : pend_epc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        wait_cnt_d   = wait_cnt_q;
        if_valid_d   = 1'b0;
        if_pc_d      = if_pc_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        fetch_err_d  = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_trap_d  = pend_trap_q;
        pend_pc_d    = pend_pc_q;
        pend_cause_d = pend_cause_q;
        pend_epc_d   = pend_epc_q;

        case (state_q)
            S_FETCH: begin
                if (imem_ack_i) begin
                    wait_cnt_d   = 8'd0;
                    pend_valid_d = 1'b0;
                    if (mrg_valid) begin
                        // Stale fetch: drop the instruction and refetch at the target.
                        pc_d = mrg_pc;
                        if (mrg_trap) begin
                            cause_d = mrg_cause;
                            epc_d   = mrg_epc;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        state_d    = S_ISSUED;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // The timeout wins over any same-cycle or pending event.
                    fetch_err_d  = 1'b1;
                    cause_d      = CAUSE_TIMEOUT;
                    epc_d        = pc_q;
                    pc_d         = TRAP_VEC;
                    wait_cnt_d   = 8'd0;
                    pend_valid_d = 1'b0;
                end else begin
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                    pend_valid_d = mrg_valid;
                    pend_trap_d  = mrg_trap;
                    pend_pc_d    = mrg_pc;
                    pend_cause_d = mrg_cause;
                    pend_epc_d   = mrg_epc;
                end
            end
            S_ISSUED: begin
                if (ev_any) begin
                    pc_d       = ev_target;
                    state_d    = S_FETCH;
                    wait_cnt_d = 8'd0;
                    if (ev_trap) begin
                        cause_d = ev_cause;
                        epc_d   = ev_epc;
                    end
                end else if (pc_en_i) begin
                    pc_d       = pc_q + XLEN'(4);
                    state_d    = S_FETCH;
                    wait_cnt_d = 8'd0;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            wait_cnt_q   <= 8'd0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            epc_q        <= '0;
            cause_q      <= CAUSE_NONE;
            fetch_err_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_pc_q    <= '0;
            pend_cause_q <= CAUSE_NONE;
            pend_epc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wait_cnt_q   <= wait_cnt_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            fetch_err_q  <= fetch_err_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            pend_pc_q    <= pend_pc_d;
            pend_cause_q <= pend_cause_d;
            pend_epc_q   <= pend_epc_d;
        end
    end

    assign iad_o       = pc_q;
    assign imem_req_o  = (state_q == S_FETCH);
    assign if_valid_o  = if_valid_q;
    assign if_pc_o     = if_pc_q;
    assign epc_o       = epc_q;
    assign cause_o     = cause_q;
    assign fetch_err_o = fetch_err_q;

endmodule
